// File: rtl/key_bcd_pkg.sv
// Shared constants, state encoding and helpers for the key-to-BCD decoder.
// The optional leading-zero blanking feature is enabled by defining
// KEY_BCD_LEADING_BLANK_EN.
package key_bcd_pkg;

    localparam int KEY_WIDTH  = 32;
    localparam int NUM_DIGITS = 10;
    localparam int BCD_WIDTH  = 4 * NUM_DIGITS;
    localparam int CNT_WIDTH  = 5;

    localparam logic [CNT_WIDTH-1:0] LAST_ITERATION = 5'd31;

    // Value of the blank mask when the displayed number is zero.
    localparam logic [NUM_DIGITS-1:0] BLANK_RESET = 10'b1111111110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef KEY_BCD_LEADING_BLANK_EN
    // Bit i is set when digit i and every digit above it are zero.
    // Digit 0 always stays visible so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] computeBlank(input logic [BCD_WIDTH-1:0] digits);
        logic [NUM_DIGITS-1:0] mask;
        logic                  allZero;
        mask    = '0;
        allZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            allZero = allZero & (digits[4*i +: 4] == 4'd0);
            mask[i] = allZero;
        end
        return mask;
    endfunction
`endif

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit corrector: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/key_bcd_decoder.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// A start pulse in IDLE captures the key; 32 SHIFT cycles later the result
// appears on bcd together with a one-cycle done tick.
// Define KEY_BCD_LEADING_BLANK_EN to add the registered leading-zero mask
// output 'blank'.
module key_bcd_decoder
    import key_bcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KEY_WIDTH-1:0]  key,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_WIDTH-1:0]  bcd
`ifdef KEY_BCD_LEADING_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0] blank
`endif
);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [KEY_WIDTH-1:0]   r_shiftReg;
    logic [BCD_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [BCD_WIDTH-1:0]   r_bcd;
    logic [BCD_WIDTH-1:0]   w_accAdjusted;
    logic [BCD_WIDTH-1:0]   w_accNext;
    logic [KEY_WIDTH-1:0]   w_shiftNext;

    // One corrector per accumulator digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_accAdjusted[4*g +: 4])
        );
    end

    // The top bit of the corrected accumulator is dropped by the shift; it is
    // always zero because a 32-bit key never exceeds ten decimal digits.
    assign w_accNext   = (w_accAdjusted << 1) | {{(BCD_WIDTH-1){1'b0}}, r_shiftReg[KEY_WIDTH-1]};
    assign w_shiftNext = r_shiftReg << 1;

    // Next-state logic and Moore outputs.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, datapath and result registers; the result is latched on the last
    // SHIFT edge so bcd changes exactly when done rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_bcd      <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shiftReg <= key;
                        r_acc      <= '0;
                        r_count    <= LAST_ITERATION;
                    end
                end
                SHIFT: begin
                    r_acc      <= w_accNext;
                    r_shiftReg <= w_shiftNext;
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        r_bcd <= w_accNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd = r_bcd;

`ifdef KEY_BCD_LEADING_BLANK_EN
    logic [NUM_DIGITS-1:0] r_blank;

    // Leading-zero mask, updated together with bcd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank <= BLANK_RESET;
        end else if (r_state == SHIFT && r_count == '0) begin
            r_blank <= computeBlank(w_accNext);
        end
    end

    assign blank = r_blank;
`endif

endmodule

// File: doc/key_bcd_decoder.md
KEY_BCD_DECODER -- requirements
Module: key_bcd_decoder

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 Port start, input, 1 bit: one-cycle request to convert key.
REQ-005 Port key, input, 32 bits: unsigned binary key, e.g. n/e/d or the value being edited.
REQ-006 Port busy, output, 1 bit: conversion in progress.
REQ-007 Port done, output, 1 bit: one-cycle tick, bcd just updated.
REQ-008 Port bcd, output, 40 bits: 10 BCD digits; digit i occupies bits [4i+3:4i], digit 0 = units.
REQ-009 Port blank, output, 10 bits: leading-zero mask, 1 = digit blanked; present only with the macro in REQ-024.

Function
REQ-010 SHALL implement states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, SHALL capture key into a 32-bit shift register, clear a 40-bit BCD accumulator, load the iteration counter with 31 and go to SHIFT.
REQ-012 Each SHIFT cycle SHALL first add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left by one bit (double-dabble).
REQ-013 SHIFT SHALL perform exactly 32 iterations; after the iteration with counter=0 it SHALL go to DONE.
REQ-014 DONE SHALL copy the accumulator to bcd, assert done for that one cycle and return to IDLE.
REQ-015 Latency: done SHALL be high exactly 33 cycles after the edge that samples start; busy SHALL be high in those 32 SHIFT cycles only.
REQ-016 bcd SHALL hold its value between done pulses and SHALL change only when done is asserted.
REQ-017 start while busy=1 or in DONE SHALL be ignored and not queued; key changes after capture SHALL NOT affect the running conversion.
REQ-018 start in the same cycle as done SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-019 Full range SHALL be supported: 0 yields all-zero digits; 4294967295 yields digits 4294967295; every output nibble SHALL be 0..9.
REQ-020 The counter SHALL be 5 bits and SHALL NOT wrap while in SHIFT.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, bcd=0, blank=10'b1111111110, and clear the accumulator, shift register and counter.
REQ-022 Reset mid-conversion SHALL abort without a done pulse; bcd SHALL read 0.
REQ-023 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-024 Macro KEY_BCD_LEADING_BLANK_EN: when defined, blank SHALL be registered at DONE. Bit i of blank SHALL be 1 iff i>=1 and digits i..9 are all zero. Digit 0 SHALL never be blanked.
REQ-025 When KEY_BCD_LEADING_BLANK_EN is undefined, the blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package key_bcd_pkg SHALL hold KEY_WIDTH=32, NUM_DIGITS=10, the state encoding (IDLE, SHIFT, DONE) and the blank reset constant.
REQ-027 Sub-module bcd_digit_adjust: combinational 4-bit add-3-if->=5 corrector, instantiated NUM_DIGITS times.
REQ-028 No other sub-modules; the FSM, counter and registers SHALL reside in key_bcd_decoder.

Verification
REQ-029 key=0, start pulse -> done at +33 cycles, bcd=0, blank=10'b1111111110.
REQ-030 key=32'd3000000000 -> bcd digits 3000000000, busy high 32 cycles, blank=0.
REQ-031 key=32'hFFFFFFFF -> bcd=40'h4294967295; then key=32'd1234567 -> bcd=40'h0001234567, blank=10'b1110000000.
REQ-032 start re-pulsed at +5 and at +33 (with done) with new key -> both ignored, single done, bcd from first key; start at +34 accepted.
REQ-033 rst_n low at +10 of conversion of 12345 -> no done, bcd=0, IDLE; next start converts normally.
REQ-034 Random 32-bit keys (>=1000), back-to-back starts -> bcd matches reference decimal, every nibble <=9.
